// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared screen geometry, sprite state encodings and vertical state type
package game_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int STAND_W  = 125;
    localparam int STAND_H  = 180;
    localparam int FLOOR_Y  = SCREEN_H - 80;

    localparam logic [9:0] GROUND_LEVEL_Y = 10'(FLOOR_Y - STAND_H);
    localparam logic [9:0] RIGHT_LIMIT_X  = 10'(SCREEN_W - STAND_W);

    localparam logic [3:0] STATE_STANDING        = 4'b0000;
    localparam logic [3:0] STATE_STANDING_ATTACK = 4'b1000;
    localparam logic [3:0] STATE_JUMPING         = 4'b0010;
    localparam logic [3:0] STATE_JUMPING_ATTACK  = 4'b1010;

    typedef enum logic {
        V_GROUNDED = 1'b0,
        V_AIRBORNE = 1'b1
    } vstate_t;

    function automatic logic [3:0] make_state(input logic attacking, input logic airborne);
        logic [3:0] s;
        case ({attacking, airborne})
            2'b00:   s = STATE_STANDING;
            2'b10:   s = STATE_STANDING_ATTACK;
            2'b01:   s = STATE_JUMPING;
            default: s = STATE_JUMPING_ATTACK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tick_edge.sv
// rtl/tick_edge.sv - samples a level at each frame tick and flags a rising edge seen at that tick
module tick_edge (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic level,
    output logic rise
);

    logic prev;

    // remember the level as it was at the last tick
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else if (tick) begin
            prev <= level;
        end
    end

    assign rise = tick & level & ~prev;

endmodule

// File: rtl/player_controller.sv
// rtl/player_controller.sv - per-frame fighter position, jump, attack and health logic
module player_controller
    import game_pkg::*;
#(
    parameter logic [9:0]        START_X       = 10'd100,
    parameter logic [9:0]        GROUND_Y      = GROUND_LEVEL_Y,
    parameter logic [9:0]        MIN_X         = 10'd0,
    parameter logic [9:0]        MAX_X         = RIGHT_LIMIT_X,
    parameter int                WALK_SPEED    = 4,
    parameter logic signed [7:0] JUMP_VEL      = 8'sd12,
    parameter logic signed [7:0] GRAVITY       = 8'sd1,
    parameter int                ATTACK_FRAMES = 15,
    parameter logic [3:0]        MAX_HEALTH    = 4'd8,
    parameter int                INVULN_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       btn_attack,
    input  logic       hit,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [3:0] state,
    output logic [3:0] health,
    output logic       dead
);

    logic [9:0]        x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic signed [7:0] vy_q, vy_d;
    vstate_t           v_q, v_d;
    logic [3:0]        hp_q, hp_d;
    logic [4:0]        inv_q, inv_d;
    logic [4:0]        atk_q, atk_d;
    logic              hit_pending;
    logic              atk_rise;

    logic              is_dead;
    logic              attacking;
    logic              take_hit;
    logic signed [10:0] nx;
    logic signed [10:0] next_y;

    tick_edge u_atk_edge (
        .clk   (clk),
        .rst   (rst),
        .tick  (frame_tick),
        .level (btn_attack),
        .rise  (atk_rise)
    );

    // next-frame values for position, velocity, vertical state, health and timers
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        vy_d   = vy_q;
        v_d    = v_q;
        hp_d   = hp_q;
        inv_d  = inv_q;
        atk_d  = atk_q;
        nx     = $signed({1'b0, x_q});
        next_y = $signed({1'b0, y_q}) - $signed({{3{vy_q[7]}}, vy_q});

        is_dead   = (hp_q == 4'd0);
        attacking = (atk_q != 5'd0);

        // a hit arriving on the tick itself counts along with one captured earlier
        take_hit = (hit_pending | hit) && (inv_q == 5'd0) && !is_dead;
        if (inv_q != 5'd0) begin
            inv_d = inv_q - 5'd1;
        end
        if (take_hit) begin
            hp_d  = hp_q - 4'd1;
            inv_d = 5'(INVULN_FRAMES);
        end

        if (is_dead) begin
            atk_d = 5'd0;
        end else if (attacking) begin
            atk_d = atk_q - 5'd1;
        end else if (atk_rise) begin
            atk_d = 5'(ATTACK_FRAMES);
        end

        // a grounded attack plants the feet; airborne attacks still drift
        if (!is_dead && !(attacking && v_q == V_GROUNDED) && (btn_left ^ btn_right)) begin
            if (btn_right) begin
                nx  = $signed({1'b0, x_q}) + 11'(WALK_SPEED);
                x_d = (nx > $signed({1'b0, MAX_X})) ? MAX_X : nx[9:0];
            end else begin
                nx  = $signed({1'b0, x_q}) - 11'(WALK_SPEED);
                x_d = (nx < $signed({1'b0, MIN_X})) ? MIN_X : nx[9:0];
            end
        end

        case (v_q)
            V_GROUNDED: begin
                if (btn_jump && !is_dead) begin
                    v_d  = V_AIRBORNE;
                    vy_d = JUMP_VEL;
                end
            end
            default: begin
                vy_d = vy_q - GRAVITY;
                if (vy_q < 0 && next_y >= $signed({1'b0, GROUND_Y})) begin
                    y_d  = GROUND_Y;
                    vy_d = 8'sd0;
                    v_d  = V_GROUNDED;
                end else if (next_y < 0) begin
                    y_d = 10'd0;
                end else begin
                    y_d = next_y[9:0];
                end
            end
        endcase
    end

    // commit the frame on each tick; latch hits that land between ticks
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q         <= START_X;
            y_q         <= GROUND_Y;
            vy_q        <= 8'sd0;
            v_q         <= V_GROUNDED;
            hp_q        <= MAX_HEALTH;
            inv_q       <= 5'd0;
            atk_q       <= 5'd0;
            hit_pending <= 1'b0;
        end else if (frame_tick) begin
            x_q         <= x_d;
            y_q         <= y_d;
            vy_q        <= vy_d;
            v_q         <= v_d;
            hp_q        <= hp_d;
            inv_q       <= inv_d;
            atk_q       <= atk_d;
            hit_pending <= 1'b0;
        end else if (hit) begin
            hit_pending <= 1'b1;
        end
    end

    assign pos_x  = x_q;
    assign pos_y  = y_q;
    assign state  = make_state(atk_q != 5'd0, v_q == V_AIRBORNE);
    assign health = hp_q;
    assign dead   = (hp_q == 4'd0);

endmodule
